rgb_gray_stream: RTL

- Parametrised successor to the first-generation grayscaler.
- Accepts byte-serial R,G,B samples from the source memory through a valid/ready handshake and computes one gray sample per pixel using a runtime-selectable conversion mode.
- Presents each result to the destination memory through a valid/ready handshake with backpressure.
- Counts pixels per frame and pulses a done strobe to the controller after N*M pixels.

---
 rtl/rgb_gray_stream.sv | 90 +++++++++
 1 files changed

// File: rtl/rgb_gray_stream.sv
// rgb_gray_stream: byte-serial RGB to gray converter with valid/ready streams and frame counting
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   gs_enable, mode     frame start/run level, conversion select latched at start
//   din/_valid/_ready   R,G,B byte stream from source memory
//   dout/_valid/_ready  gray result stream to destination memory
//   busy, pix_count     not idle, pixels delivered this frame
//   gs_done             one-cycle pulse after the last pixel of a frame
module rgb_gray_stream #(
  parameter int DW  = 8,
  parameter int N   = 480,
  parameter int M   = 320,
  parameter int PCW = $clog2(N*M+1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           gs_enable,
  input  logic [1:0]     mode,
  input  logic [DW-1:0]  din,
  input  logic           din_valid,
  output logic           din_ready,
  output logic [DW-1:0]  dout,
  output logic           dout_valid,
  input  logic           dout_ready,
  output logic           busy,
  output logic [PCW-1:0] pix_count,
  output logic           gs_done
);
  typedef enum logic [2:0] {IDLE, FILL, CALC, OUT, DONE} state_t;
  localparam int XW = DW + 10;
  localparam logic [PCW-1:0] TOTAL = PCW'(N*M);
  state_t state, state_nx;
  logic [1:0] idx, md;
  logic [DW-1:0] r, g, b, res, mx, calc;
  logic [XW-1:0] luma, avg;
  logic acc, last;
  function automatic logic [DW-1:0] sat(input logic [DW+1:0] x);
    return |x[DW+1:DW] ? '1 : x[DW-1:0];
  endfunction
  assign acc  = state == FILL && din_valid;
  assign last = pix_count + PCW'(1) == TOTAL;
  assign luma = XW'(77)*XW'(r) + XW'(150)*XW'(g) + XW'(29)*XW'(b) + XW'(128);
  assign avg  = (XW'(r) + XW'(g) + XW'(b))*XW'(85) + XW'(128);
  assign mx   = r > g ? (r > b ? r : b) : (g > b ? g : b);
  assign calc = md == 2'd0 ? sat(luma[XW-1:8]) : md == 2'd1 ? sat(avg[XW-1:8]) : md == 2'd2 ? mx : g;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = gs_enable ? FILL : IDLE;
      FILL:    state_nx = !gs_enable ? IDLE : (acc && idx == 2'd2) ? CALC : FILL;
      CALC:    state_nx = gs_enable ? OUT : IDLE;
      OUT:     state_nx = !gs_enable ? IDLE : !dout_ready ? OUT : last ? DONE : FILL;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      md        <= '0;
      r         <= '0;
      g         <= '0;
      b         <= '0;
      res       <= '0;
      pix_count <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && gs_enable) begin
        md        <= mode;
        pix_count <= '0;
        idx       <= '0;
      end
      if (acc) begin
        idx <= idx == 2'd2 ? 2'd0 : idx + 2'd1;
        if (idx == 2'd0) r <= din;
        if (idx == 2'd1) g <= din;
        if (idx == 2'd2) b <= din;
      end
      if (state == CALC) res <= calc;
      // an abort in the same cycle as the handshake drops the pixel uncounted
      if (state == OUT && dout_ready && gs_enable) pix_count <= pix_count + PCW'(1);
    end
  end
  assign din_ready  = state == FILL;
  assign dout_valid = state == OUT;
  assign dout       = dout_valid ? res : '0;
  assign busy       = state != IDLE;
  assign gs_done    = state == DONE;
endmodule
